// File: rtl/seq_cla_pkg.sv
// Shared types and sizing helpers for the nibble-serial CLA adder.
package seq_cla_pkg;

  localparam int unsigned SLICE_W   = 4;
  localparam int unsigned SLICE_LOG = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int unsigned num_slices(input int unsigned width);
    return width / SLICE_W;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width / SLICE_W);
  endfunction

endpackage

// File: rtl/cla_slice4.sv
// Combinational 4-bit carry-lookahead slice; block G/P exported for hierarchical CLA trees.
module cla_slice4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic       co_o,
  output logic       c3_o,
  output logic       g_o,
  output logic       p_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1, c2, c3, c4;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Two-level lookahead carries, no ripple between bit positions
  assign c1 = g[0] | (p[0] & ci_i);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci_i);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci_i);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci_i);

  assign s_o  = p ^ {c3, c2, c1, ci_i};
  assign co_o = c4;
  assign c3_o = c3;
  assign g_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign p_o  = &p;

endmodule

// File: rtl/seq_cla_adder.sv
// Wide adder that time-shares one 4-bit CLA slice, one nibble per cycle, LSB nibble first.
// Define SEQ_CLA_OVF_EN to add the registered signed-overflow output ovf.
module seq_cla_adder
  import seq_cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SEQ_CLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N     = num_slices(WIDTH);
  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned IDX_W = CNT_W + SLICE_LOG;

  if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("seq_cla_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               last_c;
  logic [IDX_W-1:0]   nib_base_c;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_co;
  logic               slice_c3;
  logic               unused_blk_g;
  logic               unused_blk_p;

  assign last_c     = (k_q == CNT_W'(N - 1));
  assign nib_base_c = {k_q, {SLICE_LOG{1'b0}}};

  cla_slice4 u_slice (
    .a_i  (a_q[nib_base_c +: SLICE_W]),
    .b_i  (b_q[nib_base_c +: SLICE_W]),
    .ci_i (carry_q),
    .s_o  (slice_s),
    .co_o (slice_co),
    .c3_o (slice_c3),
    .g_o  (unused_blk_g),
    .p_o  (unused_blk_p)
  );

`ifdef SEQ_CLA_OVF_EN
  logic ovf_q, ovf_d;
`else
  logic unused_c3;
  assign unused_c3 = slice_c3;
`endif

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SEQ_CLA_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[nib_base_c +: SLICE_W] = slice_s;
        carry_d = slice_co;
        k_d     = k_q + CNT_W'(1);
        if (last_c) begin
          cout_d  = slice_co;
`ifdef SEQ_CLA_OVF_EN
          ovf_d   = slice_co ^ slice_c3;
`endif
          k_d     = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef SEQ_CLA_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_seq_cla_adder.sv
// Self-checking bench for seq_cla_adder (WIDTH=16) against an arithmetic reference model.
module tb_seq_cla_adder;

  localparam int unsigned WIDTH = 16;
  localparam int          LAT   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SEQ_CLA_OVF_EN
  logic             ovf;
`endif

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  seq_cla_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SEQ_CLA_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
    int unsigned r;
    r = int'(x) + int'(y) + int'(c);
    return (WIDTH + 1)'(r);
  endfunction

`ifdef SEQ_CLA_OVF_EN
  function automatic logic ref_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic c);
    int r;
    r = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (r > 32767) || (r < -32768);
  endfunction
`endif

  // Present one operand pair for a single edge, then scramble the inputs
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc);
    in_valid = 1'b1;
    a        = ta;
    b        = tb_v;
    cin      = tc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = WIDTH'($urandom);
    b        = WIDTH'($urandom);
    cin      = 1'($urandom);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 32) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_run++;
    if ({in_ready, out_valid, cout, sum} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b cout=%b sum=%h, want rdy=1 vld=0 cout=0 sum=0000",
               in_ready, out_valid, cout, sum);
    end
`ifdef SEQ_CLA_OVF_EN
    n_run++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] va [3] = '{16'h1234, 16'hFFFF, 16'h7FFF};
    logic [WIDTH-1:0] vb [3] = '{16'h4321, 16'h0001, 16'h0000};
    logic             vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [WIDTH:0]   exp_v;
    int               cyc;
    for (int i = 0; i < 3; i++) begin
      exp_v = ref_add(va[i], vb[i], vc[i]);
      n_run++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_ready[%0d]: got %b want 1", i, in_ready);
      end
      send(va[i], vb[i], vc[i]);
      wait_valid(cyc);
      n_run++;
      if (cyc != LAT) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d cycles want %0d", i, cyc, LAT);
      end
      n_run++;
      if ({cout, sum} !== exp_v) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: got cout=%b sum=%h want cout=%b sum=%h",
                 i, cout, sum, exp_v[WIDTH], exp_v[WIDTH-1:0]);
      end
`ifdef SEQ_CLA_OVF_EN
      n_run++;
      if (ovf !== ref_ovf(va[i], vb[i], vc[i])) begin
        n_fail++;
        $display("FAIL directed_ovf[%0d]: got %b want %b", i, ovf, ref_ovf(va[i], vb[i], vc[i]));
      end
`endif
      consume();
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    send(16'h1234, 16'h4321, 1'b0);
    wait_valid(cyc);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_run++;
      if ({out_valid, cout, sum} !== {1'b1, 1'b0, 16'h5555}) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got vld=%b cout=%b sum=%h want vld=1 cout=0 sum=5555",
                 i, out_valid, cout, sum);
      end
    end
    consume();
    n_run++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL backpressure_release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    send(16'h0F0F, 16'h0101, 1'b1);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 32) begin
      n_run++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_ready[%0d]: got %b want 0", cyc, in_ready);
      end
      in_valid = 1'b1;
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      cin      = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    n_run++;
    if ({in_ready, cout, sum} !== {1'b0, 1'b0, 16'h1011}) begin
      n_fail++;
      $display("FAIL busy_result: got rdy=%b cout=%b sum=%h want rdy=0 cout=0 sum=1011",
               in_ready, cout, sum);
    end
    consume();
    n_run++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_idle_after: got %b want 1", in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int   cyc;
    logic saw_valid;
    send(16'hABCD, 16'h1111, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_run++;
    if ({in_ready, out_valid, cout, sum} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL midrun_reset: got rdy=%b vld=%b cout=%b sum=%h want rdy=1 vld=0 cout=0 sum=0000",
               in_ready, out_valid, cout, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) saw_valid = 1'b1;
    end
    n_run++;
    if (saw_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_no_valid: got out_valid pulse=%b want 0", saw_valid);
    end
    send(16'h00FF, 16'h0001, 1'b0);
    wait_valid(cyc);
    n_run++;
    if ({cyc == LAT, cout, sum} !== {1'b1, 1'b0, 16'h0100}) begin
      n_fail++;
      $display("FAIL midrun_next_txn: got lat=%0d cout=%b sum=%h want lat=%0d cout=0 sum=0100",
               cyc, cout, sum, LAT);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] ta, tb_v;
    logic             tc;
    logic [WIDTH:0]   exp_v;
    int               cyc;
    int               stall;
    for (int t = 0; t < 1000; t++) begin
      ta    = WIDTH'($urandom);
      tb_v  = WIDTH'($urandom);
      tc    = 1'($urandom);
      exp_v = ref_add(ta, tb_v, tc);
      send(ta, tb_v, tc);
      wait_valid(cyc);
      stall = int'($urandom_range(0, 3));
      repeat (stall) begin
        @(posedge clk); #1;
      end
      n_run++;
      if ({cyc == LAT, out_valid, cout, sum} !== {1'b1, 1'b1, exp_v}) begin
        n_fail++;
        $display("FAIL random[%0d]: a=%h b=%h cin=%b got lat=%0d vld=%b cout=%b sum=%h want lat=%0d vld=1 cout=%b sum=%h",
                 t, ta, tb_v, tc, cyc, out_valid, cout, sum, LAT, exp_v[WIDTH], exp_v[WIDTH-1:0]);
      end
`ifdef SEQ_CLA_OVF_EN
      n_run++;
      if (ovf !== ref_ovf(ta, tb_v, tc)) begin
        n_fail++;
        $display("FAIL random_ovf[%0d]: got %b want %b", t, ovf, ref_ovf(ta, tb_v, tc));
      end
`endif
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
